// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity modes
// and a width helper used to size counters.
package uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Bits needed to hold values 0..value-1; never less than 1 so that a
    // divide-by-2 counter still gets a real flop.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Valid/ready word handshake between a byte source and the transmitter.
interface uart_tx_ctrl_if #(
    parameter int DATA_W = 8
) ();

    logic              tx_valid;
    logic [DATA_W-1:0] data_in;
    logic              tx_ready;

    modport master (
        output tx_valid,
        output data_in,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  data_in,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_ctrl_baud_tick_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled and flags the last
// cycle of each bit period. Shared with the future receiver.
module baud_tick_gen
    import uart_tx_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = en && (count_q == LAST);

    // Next count: clear wins, otherwise wrap at the bit end while enabled.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + CNT_W'(1);
        end
    end

    // Counter register, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Self-timed UART transmitter: accepts one word per frame over a valid/ready
// handshake and serialises start, data (LSB first), optional parity and stop
// bits onto a registered, idle-high line.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 434,  // clocks per bit, >= 2
    parameter int DATA_W    = 8,    // 5..9
    parameter int PARITY    = 0,    // PAR_NONE / PAR_ODD / PAR_EVEN
    parameter int STOP_BITS = 1     // 1 or 2
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_ctrl_if.slave      tx_if,
    output logic               tx_busy,
    output logic               tx_done,
    output logic               data_tx
);

    // The bit counter serves both the data bits and the stop bits.
    localparam int BIT_W = clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              par_q, par_d;
    logic              data_tx_q, data_tx_d;
    logic              tx_done_q, tx_done_d;
    logic              accept;
    logic              tick;

    assign tx_if.tx_ready = (state_q == ST_IDLE);
    assign accept         = tx_if.tx_valid && (state_q == ST_IDLE);
    assign tx_busy        = (state_q != ST_IDLE);
    assign tx_done        = tx_done_q;
    assign data_tx        = data_tx_q;

    baud_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .en   (state_q != ST_IDLE),
        .tick (tick)
    );

    // Next-state logic; the line level is computed for the state being
    // entered so the registered output lines up with the state register.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        par_d     = par_q;
        data_tx_d = data_tx_q;
        tx_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                data_tx_d = 1'b1;
                if (accept) begin
                    shift_d   = tx_if.data_in;
                    // Parity is frozen at accept so later data_in changes
                    // cannot leak into the frame.
                    par_d     = (^tx_if.data_in) ^ (PARITY == PAR_ODD);
                    bit_d     = '0;
                    state_d   = ST_START;
                    data_tx_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    data_tx_d = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_d     = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d   = ST_PARITY;
                            data_tx_d = par_q;
                        end else begin
                            state_d   = ST_STOP;
                            data_tx_d = 1'b1;
                        end
                    end else begin
                        bit_d     = bit_q + BIT_W'(1);
                        data_tx_d = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    data_tx_d = 1'b1;
                    bit_d     = '0;
                end
            end
            ST_STOP: begin
                data_tx_d = 1'b1;
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        state_d   = ST_IDLE;
                        tx_done_d = 1'b1;
                        bit_d     = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                data_tx_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            par_q     <= 1'b0;
            data_tx_q <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            data_tx_q <= data_tx_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: five differently configured instances share a
// clock and reset; each has a frame-level model that predicts the line,
// ready, busy and done outputs every cycle.
module tb_uart_tx_ctrl;

    localparam int NI = 5;

    function automatic int cfg_div(input int i);
        return (i == 4) ? 2 : 4;
    endfunction
    function automatic int cfg_dw(input int i);
        return (i == 3) ? 7 : ((i == 4) ? 5 : 8);
    endfunction
    function automatic int cfg_par(input int i);
        return (i == 1) ? 2 : (((i == 2) || (i == 4)) ? 1 : 0);
    endfunction
    function automatic int cfg_sb(input int i);
        return ((i == 3) || (i == 4)) ? 2 : 1;
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NI-1:0] valid_v = '0;
    logic [8:0]    data_r [NI];
    logic [NI-1:0] line_w, ready_w, busy_w, done_w;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_inst
            localparam int DV = cfg_div(gi);
            localparam int DW = cfg_dw(gi);
            localparam int PR = cfg_par(gi);
            localparam int SB = cfg_sb(gi);
            localparam int NB = 1 + DW + ((PR != 0) ? 1 : 0) + SB;

            uart_tx_ctrl_if #(.DATA_W(DW)) ifc ();
            assign ifc.tx_valid = valid_v[gi];
            assign ifc.data_in  = data_r[gi][DW-1:0];
            assign ready_w[gi]  = ifc.tx_ready;

            uart_tx_ctrl #(
                .CLK_DIV(DV), .DATA_W(DW), .PARITY(PR), .STOP_BITS(SB)
            ) dut (
                .clk    (clk),
                .rst    (rst),
                .tx_if  (ifc),
                .tx_busy(busy_w[gi]),
                .tx_done(done_w[gi]),
                .data_tx(line_w[gi])
            );

            // Frame model: after an accept in cycle st, cycles st+1..st+NB*DV
            // carry the frame bits, cycle st+NB*DV+1 is the done/ready cycle.
            initial begin : model
                int          st;
                int          k;
                int          ones;
                int          idx;
                logic [11:0] fr;
                logic [3:0]  expv;
                logic [3:0]  actv;
                st = -1;
                fr = '1;
                forever begin
                    @(negedge clk);
                    expv = 4'b1100;  // {line, ready, busy, done}
                    if (!rst) begin
                        st = -1;
                    end else if (st >= 0) begin
                        k = cyc - st;
                        if (k >= 1 && k <= NB * DV) begin
                            expv = {fr[(k - 1) / DV], 1'b0, 1'b1, 1'b0};
                        end else if (k == NB * DV + 1) begin
                            expv = 4'b1101;
                            st   = -1;
                        end
                    end
                    actv = {line_w[gi], ready_w[gi], busy_w[gi], done_w[gi]};
                    chk($sformatf("inst%0d_outputs", gi), int'(actv), int'(expv));
                    if (rst && valid_v[gi] && expv[2]) begin
                        fr    = '1;
                        fr[0] = 1'b0;
                        ones  = 0;
                        for (int i = 0; i < DW; i++) begin
                            fr[1 + i] = data_r[gi][i];
                            ones += int'(data_r[gi][i]);
                        end
                        idx = 1 + DW;
                        if (PR == 2) fr[idx] = logic'(ones % 2);
                        if (PR == 1) fr[idx] = logic'(1 - (ones % 2));
                        st = cyc;
                    end
                end
            end
        end
    endgenerate

    task automatic random_cycles(input int n, input int rate);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                valid_v[i] = ($urandom_range(0, rate) == 0);
                data_r[i]  = 9'($urandom);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        @(posedge clk);
        #1;
        valid_v = '0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        logic [9:0] pat_a;
        int         dk [NI];
        int         dcount;
        pat_a = 10'b1101001010;  // 8'hA5 framed, slot 0 = start bit
        for (int i = 0; i < NI; i++) data_r[i] = '0;

        // Power-on reset, then check idle outputs.
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("reset_line", int'(line_w), 31);
        chk("reset_ready", int'(ready_w), 31);
        chk("reset_busy", int'(busy_w), 0);
        chk("reset_done", int'(done_w), 0);

        // Directed frames on every instance, accepted in the same cycle.
        @(posedge clk);
        #1;
        data_r[0] = 9'h0A5;
        data_r[1] = 9'h007;
        data_r[2] = 9'h007;
        data_r[3] = 9'h07F;
        data_r[4] = 9'h013;
        valid_v   = '1;
        @(posedge clk);
        #1;
        valid_v = '0;
        data_r[0] = 9'h15A;  // ignored after accept
        for (int i = 0; i < NI; i++) dk[i] = -1;
        for (int k = 1; k <= 47; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 39 && ((k - 3) % 4) == 0)
                chk($sformatf("a5_slot%0d", (k - 3) / 4), int'(line_w[0]), int'(pat_a[(k - 3) / 4]));
            if (k == 39) begin
                chk("even_parity_07", int'(line_w[1]), 1);
                chk("odd_parity_07", int'(line_w[2]), 0);
            end
            if (k >= 33 && k <= 40) chk("two_stop_level", int'(line_w[3]), 1);
            for (int i = 0; i < NI; i++)
                if (done_w[i] && dk[i] < 0) dk[i] = k;
            @(posedge clk);
        end
        chk("done_lat_inst0", dk[0], 41);
        chk("done_lat_inst1", dk[1], 45);
        chk("done_lat_inst2", dk[2], 45);
        chk("done_lat_inst3", dk[3], 41);
        chk("done_lat_inst4", dk[4], 19);

        // Back-to-back: valid held, 8'h55 then 8'hFF.
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) data_r[i] = 9'h055;
        valid_v = '1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) data_r[i] = 9'h0FF;
        repeat (95) @(posedge clk);
        idle_cycles(60);

        // Random traffic with data toggling and valid pulses while busy.
        random_cycles(3000, 3);
        idle_cycles(60);

        // Reset in the middle of a frame.
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) data_r[i] = 9'($urandom);
        valid_v = '1;
        @(posedge clk);
        #1;
        valid_v = '0;
        repeat (10) @(posedge clk);
        #2;
        chk("busy_before_abort", int'(busy_w), 31);
        rst = 1'b0;
        #1;
        chk("abort_line", int'(line_w), 31);
        chk("abort_ready", int'(ready_w), 31);
        chk("abort_busy", int'(busy_w), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        dcount = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_w != '0) dcount++;
        end
        chk("no_done_after_abort", dcount, 0);

        random_cycles(1000, 2);
        idle_cycles(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
